// File: rtl/ras_ckpt.sv
// Return-address stack with a checkpoint of its top pointer and occupancy.
// Supports recovery after a branch mispredict; entry contents are never rolled back.
module ras_ckpt #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [VLEN-1:0] push_addr_i,
    input  logic            pop_i,
    input  logic            ckpt_save_i,
    input  logic            ckpt_restore_i,
    output logic [VLEN-1:0] top_addr_o,
    output logic            top_valid_o,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0] TP_MAX = TW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [VLEN-1:0] entry_r [DEPTH];
    logic [TW-1:0]   tp_r;
    logic [CW-1:0]   count_r;
    logic [TW-1:0]   snap_tp_r;
    logic [CW-1:0]   snap_count_r;
    logic            overflow_r;
    logic            underflow_r;

    logic [TW-1:0]   tp_inc_s;
    logic [TW-1:0]   tp_dec_s;
    logic [TW-1:0]   tp_nxt_s;
    logic [CW-1:0]   count_nxt_s;
    logic            wr_en_s;
    logic [TW-1:0]   wr_idx_s;
    logic            overflow_nxt_s;
    logic            underflow_nxt_s;

    // Circular neighbours of the top pointer; DEPTH need not be a power of two.
    assign tp_inc_s = (tp_r == TP_MAX) ? {TW{1'b0}} : tp_r + TW'(1);
    assign tp_dec_s = (tp_r == {TW{1'b0}}) ? TP_MAX : tp_r - TW'(1);

    // Next-state selection: flush beats restore, restore beats push/pop.
    always_comb begin
        tp_nxt_s        = tp_r;
        count_nxt_s     = count_r;
        wr_en_s         = 1'b0;
        wr_idx_s        = tp_r;
        overflow_nxt_s  = 1'b0;
        underflow_nxt_s = 1'b0;
        if (flush_i) begin
            count_nxt_s = {CW{1'b0}};
        end else if (ckpt_restore_i) begin
            tp_nxt_s    = snap_tp_r;
            count_nxt_s = snap_count_r;
        end else if (push_i && pop_i) begin
            // Call and return in one cycle replace the top entry in place.
            wr_en_s  = 1'b1;
            wr_idx_s = tp_r;
            if (count_r == {CW{1'b0}}) begin
                count_nxt_s = CW'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end else if (push_i) begin
            tp_nxt_s = tp_inc_s;
            wr_en_s  = 1'b1;
            wr_idx_s = tp_inc_s;
            if (count_r == CNT_FULL) begin
                overflow_nxt_s = 1'b1;
            end else begin
                count_nxt_s = count_r + CW'(1);
            end
        end else if (pop_i) begin
            if (count_r == {CW{1'b0}}) begin
                underflow_nxt_s = 1'b1;
            end else begin
                tp_nxt_s    = tp_dec_s;
                count_nxt_s = count_r - CW'(1);
            end
        end else begin
            tp_nxt_s = tp_r;
        end
    end

    // State registers; the snapshot captures this cycle's post-update pointer and count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {VLEN{1'b0}};
            end
            tp_r         <= {TW{1'b0}};
            count_r      <= {CW{1'b0}};
            snap_tp_r    <= {TW{1'b0}};
            snap_count_r <= {CW{1'b0}};
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                entry_r[wr_idx_s] <= push_addr_i;
            end
            tp_r        <= tp_nxt_s;
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
            if (ckpt_save_i) begin
                snap_tp_r    <= tp_nxt_s;
                snap_count_r <= count_nxt_s;
            end
        end
    end

    assign top_addr_o  = entry_r[tp_r];
    assign top_valid_o = (count_r != {CW{1'b0}});
    assign count_o     = count_r;
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_ras_ckpt.sv
// Drives a DEPTH=2/VLEN=32 and a DEPTH=4/VLEN=64 stack with identical stimulus
// and compares both against an array-based reference stack.
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [63:0] addr64 = 64'h0;
    logic [31:0] addr32 = 32'h0;

    logic [31:0] top2;
    logic        vld2, ovf2, udf2;
    logic [1:0]  cnt2;
    logic [63:0] top4;
    logic        vld4, ovf4, udf4;
    logic [2:0]  cnt4;

    int n_chk = 0;
    int n_fail = 0;

    // reference state, index 0 = DEPTH 2, index 1 = DEPTH 4
    logic [63:0] m_ent [2][16];
    int          m_tp [2];
    int          m_cnt [2];
    int          m_stp [2];
    int          m_scnt [2];
    bit          m_ovf [2];
    bit          m_udf [2];

    always #5 clk = ~clk;

    ras_ckpt #(.DEPTH(2), .VLEN(32)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
        .push_addr_i(addr32), .pop_i(pop), .ckpt_save_i(save),
        .ckpt_restore_i(restore), .top_addr_o(top2), .top_valid_o(vld2),
        .count_o(cnt2), .overflow_o(ovf2), .underflow_o(udf2)
    );

    ras_ckpt #(.DEPTH(4), .VLEN(64)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
        .push_addr_i(addr64), .pop_i(pop), .ckpt_save_i(save),
        .ckpt_restore_i(restore), .top_addr_o(top4), .top_valid_o(vld4),
        .count_o(cnt4), .overflow_o(ovf4), .underflow_o(udf4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k, input int d, input logic [63:0] a);
        m_ovf[k] = 1'b0;
        m_udf[k] = 1'b0;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_ent[k][i] = 64'h0;
            m_tp[k] = 0; m_cnt[k] = 0; m_stp[k] = 0; m_scnt[k] = 0;
        end else begin
            if (flush) begin
                m_cnt[k] = 0;
            end else if (restore) begin
                m_tp[k] = m_stp[k];
                m_cnt[k] = m_scnt[k];
            end else if (push && pop) begin
                m_ent[k][m_tp[k]] = a;
                if (m_cnt[k] == 0) m_cnt[k] = 1;
            end else if (push) begin
                m_tp[k] = (m_tp[k] + 1) % d;
                m_ent[k][m_tp[k]] = a;
                if (m_cnt[k] == d) m_ovf[k] = 1'b1;
                else m_cnt[k] = m_cnt[k] + 1;
            end else if (pop) begin
                if (m_cnt[k] > 0) begin
                    m_tp[k] = (m_tp[k] + d - 1) % d;
                    m_cnt[k] = m_cnt[k] - 1;
                end else begin
                    m_udf[k] = 1'b1;
                end
            end
            if (save) begin
                m_stp[k] = m_tp[k];
                m_scnt[k] = m_cnt[k];
            end
        end
    endtask

    task automatic check_all();
        check("d2_count", 64'(cnt2), 64'(m_cnt[0]));
        check("d2_valid", 64'(vld2), 64'(m_cnt[0] != 0));
        check("d2_ovf", 64'(ovf2), 64'(m_ovf[0]));
        check("d2_udf", 64'(udf2), 64'(m_udf[0]));
        if (m_cnt[0] != 0) check("d2_top", 64'(top2), m_ent[0][m_tp[0]]);
        check("d4_count", 64'(cnt4), 64'(m_cnt[1]));
        check("d4_valid", 64'(vld4), 64'(m_cnt[1] != 0));
        check("d4_ovf", 64'(ovf4), 64'(m_ovf[1]));
        check("d4_udf", 64'(udf4), 64'(m_udf[1]));
        if (m_cnt[1] != 0) check("d4_top", top4, m_ent[1][m_tp[1]]);
    endtask

    task automatic cycle(input logic r, input logic f, input logic pu, input logic po,
                         input logic sv, input logic rs, input logic [63:0] a);
        rst = r; flush = f; push = pu; pop = po; save = sv; restore = rs;
        addr64 = a;
        addr32 = a[31:0];
        @(posedge clk);
        model_step(0, 2, {32'h0, a[31:0]});
        model_step(1, 4, a);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic do_push(input logic [63:0] a);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic do_pop();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        logic [63:0] ra;

        // reset state
        do_reset();
        check("rst_top2", 64'(top2), 64'h0);
        check("rst_top4", top4, 64'h0);

        // three pushes into a two-deep stack
        do_push(64'h100);
        do_push(64'h200);
        check("d2_no_ovf_yet", 64'(ovf2), 64'h0);
        do_push(64'h300);
        check("d2_ovf_pulse", 64'(ovf2), 64'h1);
        check("d2_full_count", 64'(cnt2), 64'h2);
        do_pop();
        check("d2_ovf_gone", 64'(ovf2), 64'h0);
        check("d2_pop_top", 64'(top2), 64'h200);
        do_pop();
        check("d2_empty", 64'(vld2), 64'h0);

        // pop while empty (both stacks empty after reset)
        do_reset();
        do_pop();
        check("d4_udf_pulse", 64'(udf4), 64'h1);
        check("d4_udf_count", 64'(cnt4), 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        check("d4_udf_gone", 64'(udf4), 64'h0);

        // simultaneous push and pop
        do_reset();
        do_push(64'h100);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h400);
        check("pp_top", top4, 64'h400);
        check("pp_count", 64'(cnt4), 64'h1);

        // checkpoint save and restore
        do_reset();
        do_push(64'h100);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        do_push(64'h200);
        do_pop();
        do_pop();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        check("rest_count", 64'(cnt4), 64'h1);
        check("rest_top", top4, 64'h100);

        // flush with push when full
        do_reset();
        do_push(64'h100);
        do_push(64'h200);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h300);
        check("flush_count", 64'(cnt2), 64'h0);
        check("flush_no_ovf", 64'(ovf2), 64'h0);
        check("flush_valid", 64'(vld2), 64'h0);

        // reset in the middle of a push sequence
        do_reset();
        do_push(64'h1111_0000_0000_0001);
        do_push(64'h2222_0000_0000_0002);
        do_push(64'h3333_0000_0000_0003);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4444_0000_0000_0004);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5555_0000_0000_0005);
        check("midrst_count", 64'(cnt4), 64'h0);
        check("midrst_top", top4, 64'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
            check("midrst_no_ovf", 64'(ovf4), 64'h0);
            check("midrst_no_udf", 64'(udf4), 64'h0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ra = {$urandom, $urandom};
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0),
                  ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
